note_player: RTL and testbench

//  Responder side of the song-reader/note-player handshake. Latches {note, duration} on a

---
 rtl/note_player.sv | 129 ++++++++++++
 tb/tb_note_player.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// Square-wave note player: latches {note, duration} on a load strobe, emits one tone
// sample per sample strobe and counts beats until the note ends.
module note_player #(
   parameter logic signed [15:0] AMPLITUDE = 16'sd8192,
   parameter int                 PHASE_W   = 22
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        play,
   input  logic        load_new_note,
   input  logic [5:0]  note,
   input  logic [5:0]  duration,
   input  logic        beat,
   input  logic        generate_next_sample,
   output logic [15:0] sample_out,
   output logic        new_sample_ready,
   output logic        note_done,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [5:0]           note_q, note_d;
   logic [5:0]           remaining_q, remaining_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [15:0]          sample_q, sample_d;
   logic                 sample_ready_q;

   logic [5:0]           note_m1;
   logic [3:0]           semi;
   logic [2:0]           oct;
   logic [13:0]          base;
   logic [PHASE_W-1:0]   step;
   logic [PHASE_W-1:0]   phase_adv;
   logic                 advance;

   // Semitone within the octave picks a base step; the octave doubles it.
   always_comb begin
      note_m1 = note_q - 6'd1;
      semi    = 4'(note_m1 % 6'd12);
      oct     = 3'(note_m1 / 6'd12);
      case (semi)
         4'd0:    base = 14'd4806;
         4'd1:    base = 14'd5092;
         4'd2:    base = 14'd5394;
         4'd3:    base = 14'd5715;
         4'd4:    base = 14'd6055;
         4'd5:    base = 14'd6415;
         4'd6:    base = 14'd6797;
         4'd7:    base = 14'd7201;
         4'd8:    base = 14'd7629;
         4'd9:    base = 14'd8083;
         4'd10:   base = 14'd8563;
         4'd11:   base = 14'd9072;
         default: base = 14'd0;
      endcase
      step = {{(PHASE_W-14){1'b0}}, base} << oct;
   end

   always_comb begin
      state_d     = state_q;
      note_d      = note_q;
      remaining_d = remaining_q;
      phase_d     = phase_q;
      sample_d    = sample_q;

      advance   = generate_next_sample && (state_q == PLAYING) && play && (note_q != 6'd0);
      phase_adv = phase_q + step;

      // A rest, pause or non-playing state still answers every strobe, with silence.
      if (generate_next_sample) begin
         if (advance) begin
            phase_d  = phase_adv;
            sample_d = phase_adv[PHASE_W-1] ? -AMPLITUDE : AMPLITUDE;
         end else begin
            sample_d = '0;
         end
      end

      case (state_q)
         IDLE: state_d = IDLE;
         PLAYING: begin
            if (beat && play) begin
               if (remaining_q <= 6'd1) state_d = DONE;
               else                     remaining_d = remaining_q - 6'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A load overrides beat counting in every state, including an in-flight note.
      if (load_new_note) begin
         note_d      = note;
         remaining_d = duration;
         phase_d     = '0;
         state_d     = (duration == 6'd0) ? DONE : PLAYING;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         note_q         <= '0;
         remaining_q    <= '0;
         phase_q        <= '0;
         sample_q       <= '0;
         sample_ready_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         note_q         <= note_d;
         remaining_q    <= remaining_d;
         phase_q        <= phase_d;
         sample_q       <= sample_d;
         sample_ready_q <= generate_next_sample;
      end
   end

   assign sample_out       = sample_q;
   assign new_sample_ready = sample_ready_q;
   assign note_done        = (state_q == DONE);
   assign busy             = (state_q == PLAYING);

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: a reference model predicts samples into a queue that a
// negedge scoreboard drains, plus per-cycle busy/note_done and targeted checks.
module tb_note_player;

   logic        clk = 1'b0;
   logic        reset, play, load_new_note, beat, generate_next_sample;
   logic [5:0]  note, duration;
   logic [15:0] sample_out;
   logic        new_sample_ready, note_done, busy;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [15:0] exp_q[$];

   // Reference model state: 0 idle, 1 playing, 2 done.
   int m_state = 0;
   int m_rem = 0;
   int m_note = 0;
   int m_phase = 0;

   note_player dut (
      .clk                  (clk),
      .reset                (reset),
      .play                 (play),
      .load_new_note        (load_new_note),
      .note                 (note),
      .duration             (duration),
      .beat                 (beat),
      .generate_next_sample (generate_next_sample),
      .sample_out           (sample_out),
      .new_sample_ready     (new_sample_ready),
      .note_done            (note_done),
      .busy                 (busy)
   );

   always #5 clk = ~clk;

   function automatic int step_of(input int n);
      int base [12] = '{4806, 5092, 5394, 5715, 6055, 6415, 6797, 7201, 7629, 8083, 8563, 9072};
      return base[(n - 1) % 12] << ((n - 1) / 12);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      int  nph;
      int  ns;
      logic adv;
      if (reset) begin
         m_state = 0; m_rem = 0; m_note = 0; m_phase = 0;
      end else begin
         nph = m_phase;
         ns  = m_state;
         adv = generate_next_sample && (m_state == 1) && play && (m_note != 0);
         if (generate_next_sample) begin
            if (adv) nph = (m_phase + step_of(m_note)) & 32'h3FFFFF;
            exp_q.push_back(adv ? (nph[21] ? 16'hE000 : 16'h2000) : 16'h0000);
         end
         if (m_state == 1) begin
            if (beat && play) begin
               if (m_rem <= 1) ns = 2;
               else            m_rem = m_rem - 1;
            end
         end else if (m_state == 2) begin
            ns = 0;
         end
         if (load_new_note) begin
            m_note = int'(note);
            m_rem  = int'(duration);
            nph    = 0;
            ns     = (duration == 6'd0) ? 2 : 1;
         end
         m_phase = nph;
         m_state = ns;
      end
   endtask

   // One clock: model consumes the driven inputs, DUT sees them at posedge, strobes drop.
   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      load_new_note        = 1'b0;
      beat                 = 1'b0;
      generate_next_sample = 1'b0;
      check("busy", busy, (m_state == 1));
      check("note_done", note_done, (m_state == 2));
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic load(input int n, input int d);
      note = 6'(n); duration = 6'(d); load_new_note = 1'b1;
      cyc();
   endtask

   task automatic beat_t();
      beat = 1'b1;
      cyc();
   endtask

   task automatic gen_t();
      generate_next_sample = 1'b1;
      cyc();
      check("new_sample_ready", new_sample_ready, 1'b1);
      idle(1);
   endtask

   // Scoreboard: every ready pulse must match the oldest predicted sample.
   always @(negedge clk) begin
      if (new_sample_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow got ready pulse expected none");
         end
         if (exp_q.size() != 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            checks++;
            assert (sample_out === e) else begin
               errors++;
               $error("FAIL sample got %0d expected %0d", $signed(sample_out), $signed(e));
            end
         end
      end
      if (note_done) done_cnt++;
   end

   initial begin
      int d0;
      reset = 1'b1; play = 1'b1; load_new_note = 1'b0; beat = 1'b0;
      generate_next_sample = 1'b0; note = '0; duration = '0;
      idle(2);
      reset = 1'b0;
      check("rst_sample", sample_out, 16'h0);
      check("rst_ready", new_sample_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", note_done, 1'b0);

      // Three spaced beats end a 3-beat note.
      d0 = done_cnt;
      load(1, 3);
      check("t1_busy", busy, 1'b1);
      for (int b = 0; b < 3; b++) begin
         idle(99);
         beat_t();
         check("t1_done", note_done, (b == 2));
      end
      check("t1_busy_end", busy, 1'b0);
      idle(2);
      check("t1_done_once", done_cnt, d0 + 1);

      // A1 tone: sign flips between strobe 436 and 437.
      load(1, 63);
      for (int k = 1; k <= 2000; k++) begin
         gen_t();
         if (k == 1)   check("t2_first", sample_out, 16'h2000);
         if (k == 436) check("t2_436", sample_out, 16'h2000);
         if (k == 437) check("t2_437", sample_out, 16'hE000);
      end

      // Reload mid-note abandons without note_done; A2 and top note with wrap.
      d0 = done_cnt;
      load(13, 63);
      for (int k = 1; k <= 220; k++) begin
         gen_t();
         if (k == 218) check("t3_a2_218", sample_out, 16'h2000);
         if (k == 219) check("t3_a2_219", sample_out, 16'hE000);
      end
      load(63, 63);
      for (int k = 1; k <= 60; k++) begin
         gen_t();
         if (k == 24) check("t3_n63_24", sample_out, 16'hE000);
         if (k == 25) check("t3_n63_wrap", sample_out, 16'h2000);
      end
      check("t3_no_done", done_cnt, d0);

      // Rest: silent samples, note_done after 2nd beat.
      load(0, 2);
      for (int k = 0; k < 3; k++) begin
         gen_t();
         check("t4_rest", sample_out, 16'h0);
      end
      beat_t();
      gen_t();
      beat_t();
      check("t4_rest_done", note_done, 1'b1);
      idle(1);
      load(5, 0);
      check("t4_zero_done", note_done, 1'b1);
      idle(1);
      check("t4_zero_clr", note_done, 1'b0);

      // Pause: beats ignored, phase frozen.
      load(63, 4);
      repeat (5) gen_t();
      beat_t();
      repeat (3) gen_t();
      beat_t();
      play = 1'b0;
      for (int k = 0; k < 3; k++) begin
         gen_t();
         check("t5_paused", sample_out, 16'h0);
      end
      beat_t();
      beat_t();
      check("t5_pause_busy", busy, 1'b1);
      play = 1'b1;
      repeat (25) gen_t();
      beat_t();
      check("t5_busy3", busy, 1'b1);
      beat_t();
      check("t5_done", note_done, 1'b1);
      idle(1);

      // Load with same-cycle beat: beat not counted.
      note = 6'd5; duration = 6'd2; load_new_note = 1'b1; beat = 1'b1;
      cyc();
      beat_t();
      check("t6_lb_busy", busy, 1'b1);
      beat_t();
      check("t6_lb_done", note_done, 1'b1);
      idle(1);

      // Reload while playing, then load during DONE.
      d0 = done_cnt;
      load(3, 5);
      beat_t();
      load(7, 1);
      check("t6_reload_done", note_done, 1'b0);
      beat_t();
      check("t6_reload_end", note_done, 1'b1);
      load(8, 2);
      check("t6_done_load", busy, 1'b1);
      beat_t();
      beat_t();
      check("t6_done_load_end", note_done, 1'b1);
      idle(2);
      check("t6_done_cnt", done_cnt, d0 + 2);

      // Reset mid-note.
      load(10, 5);
      gen_t();
      beat_t();
      d0 = done_cnt;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("t6_rst_sample", sample_out, 16'h0);
      check("t6_rst_ready", new_sample_ready, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      idle(10);
      check("t6_rst_no_done", done_cnt, d0);

      idle(3);
      check("sb_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
